// File: rtl/stack_2_reader.sv
// Read-side aligner for the row-reversing LIFO line buffer.
// Pairs SRAM data with its strobe and tags it with reversed-scan coordinates.
module stack_2_reader #(
    parameter int DWIDTH = 22,
    parameter int AWIDTH = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clken,
    input  logic              enable,
    input  logic [AWIDTH-1:0] width,
    input  logic [AWIDTH-1:0] height,
    input  logic              rd_en,
    input  logic [DWIDTH-1:0] din,
    output logic              out_valid,
    output logic [DWIDTH-1:0] out_data,
    output logic [AWIDTH-1:0] out_x,
    output logic [AWIDTH-1:0] out_y,
    output logic              out_eol,
    output logic              out_eof,
    output logic              busy
);

    localparam logic [AWIDTH-1:0] ONE = AWIDTH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_sd1;
    logic [AWIDTH-1:0] r_xcnt;
    logic [AWIDTH-1:0] r_ycnt;

    logic              w_strobe;
    logic              w_first;
    logic [AWIDTH-1:0] w_wm1;
    logic [AWIDTH-1:0] w_x;
    logic [AWIDTH-1:0] w_y;
    logic              w_xz;
    logic              w_last;

    // Outside RUN the next pixel always opens a frame, so coordinates
    // come straight from the dimensions rather than the counters.
    always_comb begin
        w_strobe = clken & enable & ~rd_en;
        w_first  = (r_state != RUN);
        w_wm1    = width - ONE;
        w_x      = w_first ? w_wm1 : r_xcnt;
        w_y      = w_first ? '0 : r_ycnt;
        w_xz     = (w_x == '0);
        w_last   = w_xz && (w_y == height - ONE);
        w_next   = r_state;
        if (r_sd1) begin
            w_next = w_last ? DONE : RUN;
        end else if (r_state != RUN) begin
            w_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sd1     <= 1'b0;
            r_state   <= IDLE;
            r_xcnt    <= '0;
            r_ycnt    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            r_sd1     <= w_strobe;
            r_state   <= w_next;
            busy      <= (w_next != IDLE);
            out_valid <= r_sd1;
            out_eol   <= r_sd1 & w_xz;
            out_eof   <= r_sd1 & w_last;
            if (r_sd1) begin
                out_data <= din;
                out_x    <= w_x;
                out_y    <= w_y;
                if (w_xz) begin
                    r_xcnt <= w_wm1;
                    r_ycnt <= w_last ? '0 : w_y + ONE;
                end else begin
                    r_xcnt <= w_x - ONE;
                    r_ycnt <= w_y;
                end
            end else if (r_state != RUN) begin
                r_xcnt <= w_wm1;
                r_ycnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_stack_2_reader.sv
// Bench for stack_2_reader: directed scenarios plus random stalls,
// checked against a pixel-index reference model.
module tb_stack_2_reader;

    localparam int DW = 22;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clken = 1'b0;
    logic          enable = 1'b0;
    logic [AW-1:0] width = AW'(4);
    logic [AW-1:0] height = AW'(2);
    logic          rd_en = 1'b1;
    logic [DW-1:0] din = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_x;
    logic [AW-1:0] out_y;
    logic          out_eol;
    logic          out_eof;
    logic          busy;

    stack_2_reader #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .clken    (clken),
        .enable   (enable),
        .width    (width),
        .height   (height),
        .rd_en    (rd_en),
        .din      (din),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_x    (out_x),
        .out_y    (out_y),
        .out_eol  (out_eol),
        .out_eof  (out_eof),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [DW-1:0] d;
        logic [AW-1:0] x;
        logic [AW-1:0] y;
        logic          eol;
        logic          eof;
    } pix_t;

    pix_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   p = 0;
    int   w = 4;
    int   h = 2;
    logic eb = 1'b0;
    logic peof = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, obs, exp, cyc);
        end
    endtask

    // Reference: a strobe in cycle n yields pixel p of the frame in n+2,
    // scanned right-to-left within each row, rows top to bottom.
    always @(posedge clk) begin
        pix_t          e;
        logic [DW-1:0] d;
        d = DW'($urandom);
        if (rst && clken && enable && !rd_en) begin
            e.due = cyc + 2;
            e.d   = d;
            e.x   = AW'(w - 1 - (p % w));
            e.y   = AW'((p / w) % h);
            e.eol = (e.x == '0);
            e.eof = (e.x == '0) && (int'(e.y) == h - 1);
            q.push_back(e);
            p = (p + 1) % (w * h);
        end
        cyc++;
        #1 din = d;
    end

    always @(negedge clk) begin
        pix_t e;
        logic ev;
        logic eeof;
        if (!rst) begin
            check("rst_valid", 32'(out_valid), 32'd0);
            check("rst_data", 32'(out_data), 32'd0);
            check("rst_x", 32'(out_x), 32'd0);
            check("rst_y", 32'(out_y), 32'd0);
            check("rst_eol", 32'(out_eol), 32'd0);
            check("rst_eof", 32'(out_eof), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
        end else begin
            ev   = 1'b0;
            eeof = 1'b0;
            if (q.size() > 0 && q[0].due == cyc) begin
                e    = q.pop_front();
                ev   = 1'b1;
                eeof = e.eof;
                check("valid", 32'(out_valid), 32'd1);
                check("data", 32'(out_data), 32'(e.d));
                check("x", 32'(out_x), 32'(e.x));
                check("y", 32'(out_y), 32'(e.y));
                check("eol", 32'(out_eol), 32'(e.eol));
                check("eof", 32'(out_eof), 32'(e.eof));
            end else begin
                check("idle_valid", 32'(out_valid), 32'd0);
                check("idle_eol", 32'(out_eol), 32'd0);
                check("idle_eof", 32'(out_eof), 32'd0);
            end
            if (ev) eb = 1'b1;
            else if (peof) eb = 1'b0;
            peof = eeof;
            check("busy", 32'(busy), 32'(eb));
        end
    end

    task automatic drive(input logic c, input logic en, input logic r);
        @(posedge clk);
        #1;
        clken  = c;
        enable = en;
        rd_en  = r;
    endtask

    task automatic do_reset(input int nw, input int nh);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        q.delete();
        p      = 0;
        eb     = 1'b0;
        peof   = 1'b0;
        w      = nw;
        h      = nh;
        width  = AW'(nw);
        height = AW'(nh);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic strobes(input int n);
        repeat (n) drive(1'b1, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        do_reset(4, 2);
        strobes(8);
        idle(5);

        do_reset(4, 1);
        strobes(2);
        repeat (3) drive(1'b0, 1'b1, 1'b0);
        strobes(2);
        idle(5);

        do_reset(1, 3);
        strobes(3);
        idle(5);

        do_reset(2, 1);
        strobes(4);
        idle(5);

        do_reset(8, 1);
        strobes(3);
        idle(1);
        do_reset(8, 1);
        strobes(8);
        idle(5);

        do_reset(3, 2);
        repeat (5) drive(1'b1, 1'b0, 1'b0);
        strobes(6);
        idle(5);

        for (int k = 0; k < 12; k++) begin
            do_reset(int'($urandom_range(1, 6)), int'($urandom_range(1, 4)));
            repeat (60) drive(($urandom % 4) != 0, ($urandom % 5) != 0,
                              ($urandom % 3) == 0);
            idle(4);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
